// File: rtl/ram_output_drain_pkg.sv
// Shared types and default frame geometry for the output frame buffer.
package ram_output_drain_pkg;

    typedef enum logic {FILL, DRAIN} drain_state_t;

    localparam int COLS   = 4;
    localparam int ROWS   = 4;
    localparam int Y_BITS = 8;

endpackage

// File: rtl/ram_output.sv
// Single-port frame RAM with a fixed LATENCY-cycle registered read path.
module ram_output #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             ena,
    input  logic             wea,
    input  logic [AW-1:0]    addra,
    input  logic [WIDTH-1:0] dina,
    output logic [WIDTH-1:0] douta
);

    logic [WIDTH-1:0] mem  [DEPTH];
    logic [WIDTH-1:0] pipe [LATENCY];

    // Later stages advance every cycle so the read latency never stretches.
    always_ff @(posedge clk) begin
        if (ena) begin
            if (wea) mem[addra] <= dina;
            pipe[0] <= mem[addra];
        end
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end

    assign douta = pipe[LATENCY-1];

endmodule

// File: rtl/ram_output_drain.sv
// Frame buffer: fill DEPTH words, then drain them in order through a
// credit-counted skid FIFO that hides the RAM read latency.
module ram_output_drain
    import ram_output_drain_pkg::*;
#(
    parameter int DEPTH   = COLS * ROWS,
    parameter int WIDTH   = Y_BITS,
    parameter int LATENCY = 2,
    parameter int SKID    = LATENCY + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             err_last
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (SKID > 1) ? $clog2(SKID) : 1;
    localparam int CW = $clog2(SKID + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

    drain_state_t state, state_nxt;
    logic [AW-1:0]      wr_addr;
    logic [AW:0]        rd_addr;
    logic [LATENCY-1:0] inflight, inflight_last;
    logic [WIDTH:0]     fifo_mem [SKID];
    logic [PW-1:0]      wp, rp;
    logic [CW-1:0]      count;
    logic               wr_en, issue, issue_last, push, pop;
    logic               ena, wea;
    logic [AW-1:0]      addra;
    logic [WIDTH-1:0]   douta;
    int                 in_use;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SKID - 1)) ? '0 : p + 1'b1;
    endfunction

    assign s_ready    = (state == FILL);
    assign m_valid    = (count != '0);
    assign pop        = m_valid & m_ready;
    assign push       = inflight[LATENCY-1];
    assign m_data     = fifo_mem[rp][WIDTH-1:0];
    assign m_last     = m_valid & fifo_mem[rp][WIDTH];
    assign issue_last = (rd_addr == (AW + 1)'(DEPTH - 1));

    // A word popped this cycle frees its slot for a read issued this cycle.
    assign in_use = $countones(inflight) + int'(count) - int'(pop);

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        issue     = 1'b0;
        ena       = 1'b0;
        wea       = 1'b0;
        addra     = wr_addr;
        case (state)
            FILL: begin
                wr_en = s_valid;
                ena   = s_valid;
                wea   = s_valid;
                if (s_valid && wr_addr == LAST_ADDR) state_nxt = DRAIN;
            end
            DRAIN: begin
                ena   = 1'b1;
                addra = rd_addr[AW-1:0];
                issue = (rd_addr < DEPTH_W) && (in_use < SKID);
                if (pop && m_last) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FILL;
            wr_addr       <= '0;
            rd_addr       <= '0;
            inflight      <= '0;
            inflight_last <= '0;
            err_last      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wr_en) begin
                wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
                if (s_last != (wr_addr == LAST_ADDR)) err_last <= 1'b1;
            end
            if (state == DRAIN && pop && m_last) rd_addr <= '0;
            else if (issue)                      rd_addr <= rd_addr + 1'b1;
            inflight[0]      <= issue;
            inflight_last[0] <= issue & issue_last;
            for (int i = 1; i < LATENCY; i++) begin
                inflight[i]      <= inflight[i-1];
                inflight_last[i] <= inflight_last[i-1];
            end
        end
    end

    // Skid FIFO: the last-word tag rides in the top bit of each entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < SKID; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wp] <= {inflight_last[LATENCY-1], douta};
                wp           <= ptr_inc(wp);
            end
            if (pop) rp <= ptr_inc(rp);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    ram_output #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .LATENCY(LATENCY),
        .AW     (AW)
    ) u_ram (
        .clk  (clk),
        .ena  (ena),
        .wea  (wea),
        .addra(addra),
        .dina (s_data),
        .douta(douta)
    );

endmodule

// File: tb/tb_ram_output_drain.sv
// Directed bench for ram_output_drain: scoreboard of filled words against drained beats.
module tb_ram_output_drain;

    localparam int DEPTH   = 16;
    localparam int WIDTH   = 8;
    localparam int LATENCY = 2;
    localparam int SKID    = LATENCY + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic             s_last = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic             m_last;
    logic             err_last;

    int total = 0;
    int passes = 0;
    int credit_viol = 0;
    logic [WIDTH:0] q[$];

    ram_output_drain #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .LATENCY(LATENCY), .SKID(SKID)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .err_last(err_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Output monitor: scoreboard pop, hold stability, credit bound, refill timing.
    logic             hold_prev = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic             prev_last = 1'b0;
    logic             last_hs = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
            last_hs   = 1'b0;
        end else begin
            if ($countones(dut.inflight) + int'(dut.count) > SKID) credit_viol++;
            if (last_hs) chk("s_ready_after_last", s_ready, 1);
            if (hold_prev) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                if (q.size() == 0) chk("spurious_beat", q.size(), 1);
                else begin
                    logic [WIDTH:0] e;
                    e = q.pop_front();
                    chk("m_data", m_data, e[WIDTH-1:0]);
                    chk("m_last", m_last, e[WIDTH]);
                end
            end
            hold_prev = m_valid & ~m_ready;
            prev_data = m_data;
            prev_last = m_last;
            last_hs   = m_valid & m_ready & m_last;
        end
    end

    task automatic fill_frame(input int mode, input int last_at);
        logic [WIDTH-1:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            d = (mode == 0) ? WIDTH'(i) : WIDTH'($urandom);
            s_valid = 1'b1;
            s_data  = d;
            s_last  = (i == last_at);
            q.push_back({(i == DEPTH - 1), d});
            @(posedge clk); #1;
            if (last_at == 5 && i == 4) chk("err_before_beat5", err_last, 0);
            if (last_at == 5 && i == 5) chk("err_from_beat5", err_last, 1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain(input int ready_pct, input int budget);
        int n = 0;
        while ((q.size() != 0 || !s_ready) && n < budget) begin
            m_ready = ($urandom_range(99) < ready_pct);
            @(posedge clk); #1;
            n++;
        end
        chk("drain_in_budget", (n < budget), 1);
        chk("drain_queue_empty", q.size(), 0);
        m_ready = 1'b1;
    endtask

    // From the first valid beat, DEPTH consecutive valid cycles are required.
    task automatic expect_streaming(input string tag);
        int gaps = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!m_valid) gaps++;
            @(posedge clk); #1;
        end
        chk(tag, gaps, 0);
    endtask

    initial begin
        int cyc;
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_err_last", err_last, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: address pattern, always ready
        m_ready = 1'b1;
        fill_frame(0, DEPTH - 1);
        chk("t1_s_ready_drain", s_ready, 0);
        cyc = 0;
        while (!m_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t1_first_valid_latency", cyc, LATENCY + 1);
        expect_streaming("t1_bubbles");
        chk("t1_refill_ready", s_ready, 1);
        chk("t1_queue_empty", q.size(), 0);

        // T2: random backpressure, three random frames
        for (int f = 0; f < 3; f++) begin
            fill_frame(1, DEPTH - 1);
            drain(50, 2000);
        end
        chk("t2_err_last", err_last, 0);

        // T3: stalled from drain entry, then released
        m_ready = 1'b0;
        fill_frame(1, DEPTH - 1);
        repeat (20) begin
            m_ready = 1'b0;
            @(posedge clk); #1;
        end
        chk("t3_reads_issued", dut.rd_addr, SKID);
        chk("t3_valid_held", m_valid, 1);
        chk("t3_word0", m_data, q[0][WIDTH-1:0]);
        m_ready = 1'b1;
        expect_streaming("t3_release_bubbles");
        chk("t3_queue_empty", q.size(), 0);

        // T4: early s_last at beat 5, none at DEPTH-1
        fill_frame(1, 5);
        drain(100, 500);
        chk("t4_err_sticky", err_last, 1);

        // T5: reset while word 4 is pending
        fill_frame(1, DEPTH - 1);
        n = 0;
        while (q.size() > DEPTH - 4 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("t5_word4_pending", m_valid, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_m_valid", m_valid, 0);
        chk("t5_rst_s_ready", s_ready, 1);
        chk("t5_rst_err_last", err_last, 0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        fill_frame(1, DEPTH - 1);
        drain(100, 500);
        chk("t5_err_after", err_last, 0);

        // T6: s_valid held high across two frames
        n = 0;
        cyc = 0;
        m_ready = 1'b1;
        while (n < 2 * DEPTH && cyc < 500) begin
            logic [WIDTH-1:0] d;
            d = WIDTH'($urandom);
            s_valid = 1'b1;
            s_data  = d;
            s_last  = ((n % DEPTH) == DEPTH - 1);
            if (s_ready) begin
                q.push_back({((n % DEPTH) == DEPTH - 1), d});
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("t6_beats_accepted", n, 2 * DEPTH);
        drain(100, 500);
        chk("t6_err_last", err_last, 0);

        chk("credit_violations", credit_viol, 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
